// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parametrised FIFO.
package fifo_pkg;

  localparam int unsigned FIFO_DATA_WIDTH = 32;
  localparam int unsigned FIFO_DEPTH      = 8;

  // Width of a counter that holds 0..depth inclusive.
  function automatic int unsigned level_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Advance a pointer, wrapping after depth-1 (depth need not be a power of two).
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: one write port, one registered read port with enable.
module fifo_mem #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned AW         = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Storage array write; contents survive reset.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Read register: loads only on an accepted read, so it holds otherwise.
  // A same-edge write to the read address returns the old word.
  always_ff @(posedge clk) begin
    if (!rst_n)    rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with level, thresholds, flush and error pulses.
module fifo_param
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int unsigned DEPTH      = FIFO_DEPTH,
  parameter int unsigned AF_LEVEL   = DEPTH - 2,
  parameter int unsigned AE_LEVEL   = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clear_in,
  input  logic                           we_in,
  input  logic [DATA_WIDTH-1:0]          data_in,
  input  logic                           re_in,
  output logic [DATA_WIDTH-1:0]          data_out,
  output logic                           full_out,
  output logic                           one_p_out,
  output logic                           empty_out,
  output logic                           one_d_out,
  output logic                           almost_full_out,
  output logic                           almost_empty_out,
  output logic [level_width(DEPTH)-1:0]  level_out,
  output logic                           overflow_out,
  output logic                           underflow_out
);

  localparam int unsigned LW = level_width(DEPTH);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Parameter legality, caught at elaboration.
  if (DATA_WIDTH < 1) begin : g_bad_width
    $error("fifo_param: DATA_WIDTH must be >= 1");
  end
  if (DEPTH < 2) begin : g_bad_depth
    $error("fifo_param: DEPTH must be >= 2");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
    $error("fifo_param: AF_LEVEL must be in 1..DEPTH");
  end
  if (AE_LEVEL > DEPTH - 1) begin : g_bad_ae
    $error("fifo_param: AE_LEVEL must be in 0..DEPTH-1");
  end

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          rd_ok, wr_ok;
  logic          is_full, is_empty;

  assign is_full  = (level_q == LW'(DEPTH));
  assign is_empty = (level_q == '0);

  // A read frees a slot in the same cycle, so a full FIFO still takes a write
  // when it is also being read.
  assign rd_ok = re_in && !is_empty;
  assign wr_ok = we_in && (!is_full || rd_ok);

  // Next-state: pointers, level and error pulses; flush overrides requests.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    if (clear_in) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      if (wr_ok) wptr_d = PW'(ptr_inc(32'(wptr_q), DEPTH));
      if (rd_ok) rptr_d = PW'(ptr_inc(32'(rptr_q), DEPTH));
      unique case ({wr_ok, rd_ok})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
      ovf_d = we_in && !wr_ok;
      unf_d = re_in && !rd_ok;
    end
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (PW)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (wr_ok && !clear_in && rst_n),
    .waddr_i (wptr_q),
    .wdata_i (data_in),
    .re_i    (rd_ok && !clear_in && rst_n),
    .raddr_i (rptr_q),
    .rdata_o (data_out)
  );

  assign full_out         = is_full;
  assign one_p_out        = (level_q == LW'(DEPTH - 1));
  assign empty_out        = is_empty;
  assign one_d_out        = (level_q == LW'(1));
  assign almost_full_out  = (level_q >= LW'(AF_LEVEL));
  assign almost_empty_out = (level_q <= LW'(AE_LEVEL));
  assign level_out        = level_q;
  assign overflow_out     = ovf_q;
  assign underflow_out    = unf_q;

endmodule

// File: tb/tb_fifo_param.sv
// Bench for fifo_param: constant vector table, corner sequences, random vs queue model.
module tb_fifo_param;

  localparam int unsigned DW = 32;
  localparam int unsigned D  = 8;
  localparam int unsigned AF = 6;
  localparam int unsigned AE = 1;

  logic          clk = 1'b0;
  logic          rst_n, clear_in, we_in, re_in;
  logic [DW-1:0] data_in, data_out;
  logic          full_out, one_p_out, empty_out, one_d_out;
  logic          almost_full_out, almost_empty_out, overflow_out, underflow_out;
  logic [3:0]    level_out;

  fifo_param #(.DATA_WIDTH(DW), .DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk(clk), .rst_n(rst_n), .clear_in(clear_in), .we_in(we_in), .data_in(data_in),
    .re_in(re_in), .data_out(data_out), .full_out(full_out), .one_p_out(one_p_out),
    .empty_out(empty_out), .one_d_out(one_d_out), .almost_full_out(almost_full_out),
    .almost_empty_out(almost_empty_out), .level_out(level_out),
    .overflow_out(overflow_out), .underflow_out(underflow_out)
  );

  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;

  // Reference model: a plain queue of stored words.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_dout;
  logic          m_ovf, m_unf;

  typedef struct {
    logic          clr, we, re;
    logic [DW-1:0] din;
    int unsigned   lvl;
    logic [DW-1:0] dout;
    logic [5:0]    flg;   // {full, one_p, empty, one_d, almost_full, almost_empty}
    logic          ovf, unf;
  } vec_t;
  vec_t vecs[$];

  function automatic logic [5:0] act_flags();
    return {full_out, one_p_out, empty_out, one_d_out, almost_full_out, almost_empty_out};
  endfunction

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_dout = '0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
  endtask

  task automatic model_step(input logic clr, input logic we, input logic re, input logic [DW-1:0] din);
    bit rd, wr;
    if (clr) begin
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      rd = re && (mq.size() > 0);
      wr = we && (mq.size() < D || rd);
      if (rd) m_dout = mq.pop_front();
      if (wr) mq.push_back(din);
      m_ovf = we && !wr;
      m_unf = re && !rd;
    end
  endtask

  task automatic check_model();
    int unsigned n;
    logic [5:0]  ef;
    n  = mq.size();
    ef = {n == D, n == D - 1, n == 0, n == 1, n >= AF, n <= AE};
    chk("m_level", 32'(level_out), n);
    chk("m_dout", data_out, m_dout);
    chk("m_flags", 32'(act_flags()), 32'(ef));
    chk("m_ovf", 32'(overflow_out), 32'(m_ovf));
    chk("m_unf", 32'(underflow_out), 32'(m_unf));
  endtask

  // One clock: drive inputs, step the model at the edge, compare just after it.
  task automatic cycle(input logic clr, input logic we, input logic re, input logic [DW-1:0] din);
    clear_in = clr; we_in = we; re_in = re; data_in = din;
    @(posedge clk);
    model_step(clr, we, re, din);
    #1;
    check_model();
  endtask

  task automatic reset_cycle(input logic we, input logic [DW-1:0] din);
    rst_n = 1'b0; clear_in = 1'b0; we_in = we; re_in = 1'b0; data_in = din;
    @(posedge clk);
    model_reset();
    #1;
    rst_n = 1'b1;
    check_model();
  endtask

  function automatic void add(input logic we, input logic re, input logic [DW-1:0] din,
                              input int unsigned lvl, input logic [DW-1:0] dout,
                              input logic [5:0] flg, input logic ovf, input logic unf);
    vec_t v;
    v.clr = 1'b0; v.we = we; v.re = re; v.din = din; v.lvl = lvl;
    v.dout = dout; v.flg = flg; v.ovf = ovf; v.unf = unf;
    vecs.push_back(v);
  endfunction

  initial begin
    rst_n = 1'b1; clear_in = 1'b0; we_in = 1'b0; re_in = 1'b0; data_in = '0;
    model_reset();

    // Fill 1..8, overflow, drain 1..8, underflow: expected values written out by hand.
    add(1, 0, 32'h1, 1, 0, 6'b000101, 0, 0);
    add(1, 0, 32'h2, 2, 0, 6'b000000, 0, 0);
    add(1, 0, 32'h3, 3, 0, 6'b000000, 0, 0);
    add(1, 0, 32'h4, 4, 0, 6'b000000, 0, 0);
    add(1, 0, 32'h5, 5, 0, 6'b000000, 0, 0);
    add(1, 0, 32'h6, 6, 0, 6'b000010, 0, 0);
    add(1, 0, 32'h7, 7, 0, 6'b010010, 0, 0);
    add(1, 0, 32'h8, 8, 0, 6'b100010, 0, 0);
    add(1, 0, 32'h9, 8, 0, 6'b100010, 1, 0);
    add(0, 0, 32'h0, 8, 0, 6'b100010, 0, 0);
    add(0, 1, 32'h0, 7, 1, 6'b010010, 0, 0);
    add(0, 1, 32'h0, 6, 2, 6'b000010, 0, 0);
    add(0, 1, 32'h0, 5, 3, 6'b000000, 0, 0);
    add(0, 1, 32'h0, 4, 4, 6'b000000, 0, 0);
    add(0, 1, 32'h0, 3, 5, 6'b000000, 0, 0);
    add(0, 1, 32'h0, 2, 6, 6'b000000, 0, 0);
    add(0, 1, 32'h0, 1, 7, 6'b000101, 0, 0);
    add(0, 1, 32'h0, 0, 8, 6'b001001, 0, 0);
    add(0, 1, 32'h0, 0, 8, 6'b001001, 0, 1);
    add(0, 0, 32'h0, 0, 8, 6'b001001, 0, 0);

    // Reset then idle.
    reset_cycle(1'b0, '0);
    cycle(0, 0, 0, '0);
    chk("rst_level", 32'(level_out), 0);
    chk("rst_flags", 32'(act_flags()), 32'(6'b001001));
    chk("rst_dout", data_out, 0);
    chk("rst_ovf_unf", 32'({overflow_out, underflow_out}), 0);

    foreach (vecs[i]) begin
      cycle(vecs[i].clr, vecs[i].we, vecs[i].re, vecs[i].din);
      chk($sformatf("vec%0d_level", i), 32'(level_out), vecs[i].lvl);
      chk($sformatf("vec%0d_dout", i), data_out, vecs[i].dout);
      chk($sformatf("vec%0d_flags", i), 32'(act_flags()), 32'(vecs[i].flg));
      chk($sformatf("vec%0d_ovf", i), 32'(overflow_out), 32'(vecs[i].ovf));
      chk($sformatf("vec%0d_unf", i), 32'(underflow_out), 32'(vecs[i].unf));
    end

    // Full with simultaneous write and read, then drain to show pointer wrap.
    for (int i = 0; i < 8; i++) cycle(0, 1, 0, 32'h10 + i);
    cycle(0, 1, 1, 32'hA5);
    chk("fullrw_level", 32'(level_out), 8);
    chk("fullrw_ovf", 32'(overflow_out), 0);
    chk("fullrw_dout", data_out, 32'h10);
    for (int i = 0; i < 8; i++) cycle(0, 0, 1, '0);
    chk("wrap_last", data_out, 32'hA5);
    chk("wrap_empty", 32'(empty_out), 1);

    // Empty with simultaneous write and read: write only, underflow pulse.
    cycle(0, 1, 1, 32'h77);
    chk("emptyrw_unf", 32'(underflow_out), 1);
    chk("emptyrw_level", 32'(level_out), 1);
    chk("emptyrw_dout", data_out, 32'hA5);
    cycle(0, 0, 1, '0);
    chk("emptyrw_read", data_out, 32'h77);
    chk("emptyrw_unf_clr", 32'(underflow_out), 0);

    // Flush mid-burst at level 5.
    for (int i = 0; i < 5; i++) cycle(0, 1, 0, 32'h30 + i);
    chk("pre_flush_level", 32'(level_out), 5);
    cycle(1, 1, 0, 32'hEE);
    chk("flush_level", 32'(level_out), 0);
    chk("flush_empty", 32'(empty_out), 1);
    chk("flush_err", 32'({overflow_out, underflow_out}), 0);
    chk("flush_dout_hold", data_out, 32'h77);
    cycle(0, 1, 0, 32'h44);
    cycle(0, 0, 1, '0);
    chk("post_flush_read", data_out, 32'h44);

    // Reset mid-burst zeroes data_out too.
    for (int i = 0; i < 5; i++) cycle(0, 1, 0, 32'h50 + i);
    reset_cycle(1'b1, 32'hDD);
    chk("rstmid_level", 32'(level_out), 0);
    chk("rstmid_dout", data_out, 0);
    chk("rstmid_flags", 32'(act_flags()), 32'(6'b001001));

    // Random traffic in write-heavy, read-heavy and balanced phases.
    for (int i = 0; i < 900; i++) begin
      int unsigned ph, pw, pr;
      ph = (i / 100) % 3;
      pw = (ph == 0) ? 75 : (ph == 1) ? 25 : 50;
      pr = (ph == 0) ? 25 : (ph == 1) ? 75 : 50;
      cycle($urandom_range(0, 39) == 0,
            $urandom_range(0, 99) < pw,
            $urandom_range(0, 99) < pr,
            $urandom());
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/fifo_param.md
# fifo_param

Parametrised synchronous FIFO: the next-generation FIFO DUT, generalised in data width and depth. Adds a fill-level output, programmable almost-full/almost-empty thresholds, a synchronous flush, and one-cycle overflow/underflow error pulses, alongside the existing full, one-place-left, empty and one-data-left flags. It is the DUT under the FIFO UVM bench, driven through the bench's pin interface.

## Interface
- DATA_WIDTH, 32: word width in bits, ≥1.
- DEPTH, 8: number of storage words, ≥2; need not be a power of two.
- AF_LEVEL, DEPTH-2: almost_full_out asserts when level ≥ AF_LEVEL; legal range 1..DEPTH.
- AE_LEVEL, 1: almost_empty_out asserts when level ≤ AE_LEVEL; legal range 0..DEPTH-1.
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- clear_in  in  1  synchronous flush; priority over we_in/re_in.
- we_in  in  1  write request.
- data_in  in  DATA_WIDTH  write data.
- re_in  in  1  read request.
- data_out  out  DATA_WIDTH  registered read data.
- full_out  out  1  level == DEPTH.
- one_p_out  out  1  level == DEPTH-1 (one place left).
- empty_out  out  1  level == 0.
- one_d_out  out  1  level == 1 (one data left).
- almost_full_out  out  1  level ≥ AF_LEVEL.
- almost_empty_out  out  1  level ≤ AE_LEVEL.
- level_out  out  $clog2(DEPTH+1)  current word count.
- overflow_out  out  1  one-cycle pulse: write dropped.
- underflow_out  out  1  one-cycle pulse: read dropped.

## Operation
- State: write pointer, read pointer (0..DEPTH-1, wrap to 0 after DEPTH-1, no power-of-two assumption), level counter 0..DEPTH, data_out register, two error-pulse registers.
- Reset (rst_n=0 at an edge): pointers=0, level=0, data_out=0, overflow/underflow=0. Outputs after reset: empty_out=1, almost_empty_out=1, all other flags 0, level_out=0. Memory contents are not cleared.
- clear_in=1 (rst_n=1): pointers=0, level=0, we_in/re_in ignored, no error pulses, data_out holds.
- Write accepted when we_in=1 and (level<DEPTH, or level==DEPTH with an accepted read in the same cycle). Data stored at the write pointer; the pointer advances.
- Read accepted when re_in=1 and level>0. data_out loads the word at the read pointer; the pointer advances. On a refused read, data_out holds.
- Simultaneous read and write:
  - 0<level<DEPTH: both performed, level unchanged.
  - Full: both performed, level stays DEPTH, no overflow.
  - Empty: write only, underflow_out pulses; there is no fall-through to data_out.
- Writes are refused only when full with no read; reads are refused only when empty.
- A refused write pulses overflow_out; a refused read pulses underflow_out. Each pulse lasts exactly the next cycle, and FIFO state is unchanged.
- All flags and level_out are decoded combinationally from the level register only. No input-to-output combinational paths exist.

## Timing
- A write accepted at edge N is reflected in level_out and the flags after edge N. The word is readable from edge N+1.
- Read latency is 1: re_in sampled at edge N gives data_out valid after edge N, held until the next accepted read.
- overflow_out/underflow_out are high for the single cycle following the offending edge.
- Reset or clear mid-burst takes effect at the same edge; in-flight requests at that edge are discarded.
- Sustained throughput is one write and one read per cycle.

## Structure
- Package fifo_pkg holds:
  - default constants FIFO_DATA_WIDTH=32, FIFO_DEPTH=8;
  - a level-width function returning $clog2(depth+1);
  - a pointer-increment-with-wrap function parametrised by depth.
- Sub-module fifo_mem: DEPTH×DATA_WIDTH array, one write port, one registered read port with enable. fifo_param owns the pointers, level, flags and error pulses.
- Parameter legality (DEPTH≥2, threshold ranges) is checked with elaboration-time assertions.

## Test plan
- Reset then idle (DEPTH=8, AF=6, AE=1): level_out=0, empty_out=1, almost_empty_out=1, data_out=0, every other flag 0.
- Fill: write 0x1..0x8 on consecutive cycles. Expected:
  - one_d_out at level 1;
  - almost_empty_out drops at level 2;
  - almost_full_out rises at 6;
  - one_p_out at 7;
  - full_out at 8.
  A 9th write (0x9) pulses overflow_out for 1 cycle and level stays 8.
- Drain: 8 reads give data_out 0x1..0x8 in order, each one cycle after its re_in. A 9th read pulses underflow_out and data_out holds 0x8.
- Full with simultaneous we/re (data 0xA5): level stays 8, no overflow. data_out shows the oldest word. After 8 further reads, 0xA5 comes out last, proving pointer wrap.
- Empty with simultaneous we/re (0x77): underflow pulses, level becomes 1, next read returns 0x77.
- Flush mid-burst at level 5: clear_in together with we_in gives level 0 and empty_out=1, with no overflow/underflow. A repeat with rst_n=0 mid-burst also zeroes data_out.
